// File: rtl/uart_arb_pkg.sv
// Shared types and register map for the multi-core UART bus arbiter.
// Register offsets are those of the UART core's device port.
package uart_arb_pkg;

  typedef enum logic {
    UNLOCKED = 1'b0,
    LOCKED   = 1'b1
  } lock_state_t;

  localparam int unsigned UartRxReg     = 32'h0;
  localparam int unsigned UartTxReg     = 32'h1;
  localparam int unsigned UartStatusReg = 32'h2;

  localparam logic [7:0] NewlineChar = 8'h0A;

  function automatic logic is_newline(input logic [7:0] ch);
    return ch == NewlineChar;
  endfunction

endpackage

// File: rtl/uart_rr_picker.sv
// Combinational round-robin picker: grants the first eligible index at or
// after ptr, wrapping from N-1 back to 0.
module uart_rr_picker
  import uart_arb_pkg::*;
#(
  parameter int N    = 4,
  parameter int IdxW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]    eligible,
  input  logic [IdxW-1:0] ptr,
  output logic [N-1:0]    gnt,
  output logic [IdxW-1:0] gnt_idx
);

  localparam int SumW = IdxW + 1;

  logic            found;
  logic [SumW-1:0] cand_sum;
  logic [IdxW-1:0] cand;

  // One extra bit in the sum lets ptr+offset be wrapped for any N, not only powers of two.
  always_comb begin
    gnt      = '0;
    gnt_idx  = '0;
    found    = 1'b0;
    cand_sum = '0;
    cand     = '0;
    for (int off = 0; off < N; off++) begin
      cand_sum = {1'b0, ptr} + SumW'(off);
      if (cand_sum >= SumW'(N)) begin
        cand_sum = cand_sum - SumW'(N);
      end
      cand = cand_sum[IdxW-1:0];
      if (!found && eligible[cand]) begin
        found        = 1'b1;
        gnt[cand]    = 1'b1;
        gnt_idx      = cand;
      end
    end
  end

endmodule

// File: rtl/uart_bus_arbiter.sv
// Shares one UART device port between NumReq cores with round-robin grants,
// one-cycle response routing and a per-line TX lock so lines never interleave.
module uart_bus_arbiter
  import uart_arb_pkg::*;
#(
  parameter int NumReq      = 4,
  parameter int DataWidth   = 32,
  parameter int RegAddr     = 12,
  parameter int LockTimeout = 4096
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic [NumReq-1:0]           req_i,
  input  logic [NumReq*RegAddr-1:0]   addr_i,
  input  logic [NumReq-1:0]           we_i,
  input  logic [NumReq*4-1:0]         be_i,
  input  logic [NumReq*DataWidth-1:0] wdata_i,
  output logic [NumReq-1:0]           gnt_o,
  output logic [NumReq-1:0]           rvalid_o,
  output logic [DataWidth-1:0]        rdata_o,
  output logic                        device_req_o,
  output logic [RegAddr-1:0]          device_addr_o,
  output logic                        device_we_o,
  output logic [3:0]                  device_be_o,
  output logic [DataWidth-1:0]        device_wdata_o,
  input  logic                        device_rvalid_i,
  input  logic [DataWidth-1:0]        device_rdata_i
);

  localparam int IdxW = $clog2(NumReq);
  localparam int CntW = $clog2(LockTimeout + 1);

  logic [NumReq-1:0] tx_write;
  logic [NumReq-1:0] newline;
  logic [NumReq-1:0] blocked;
  logic [NumReq-1:0] eligible;
  logic [NumReq-1:0] gnt;
  logic [IdxW-1:0]   gnt_idx;
  logic              gnt_any;
  logic              gnt_tx;
  logic              gnt_nl;
  logic [IdxW-1:0]   next_ptr;

  logic [IdxW-1:0]   ptr_q;
  lock_state_t       lock_q;
  logic [IdxW-1:0]   owner_q;
  logic [CntW-1:0]   cnt_q;
  logic [IdxW-1:0]   owner_rsp_q;
  logic              rsp_pend_q;

  // Only TX data writes from non-owners are held back; every other access passes.
  for (genvar g = 0; g < NumReq; g++) begin : g_decode
    assign tx_write[g] = req_i[g] & we_i[g] & be_i[4*g]
                       & (addr_i[g*RegAddr +: RegAddr] == RegAddr'(UartTxReg));
    assign newline[g]  = is_newline(wdata_i[g*DataWidth +: 8]);
    assign blocked[g]  = (lock_q == LOCKED) && (owner_q != IdxW'(g)) && tx_write[g];
    assign rvalid_o[g] = device_rvalid_i & rsp_pend_q & (owner_rsp_q == IdxW'(g));
  end

  assign eligible = req_i & ~blocked & {NumReq{~rst_i}};

  uart_rr_picker #(
    .N    (NumReq),
    .IdxW (IdxW)
  ) u_picker (
    .eligible (eligible),
    .ptr      (ptr_q),
    .gnt      (gnt),
    .gnt_idx  (gnt_idx)
  );

  assign gnt_o    = gnt;
  assign gnt_any  = |gnt;
  assign gnt_tx   = gnt_any & tx_write[gnt_idx];
  assign gnt_nl   = newline[gnt_idx];
  assign next_ptr = (gnt_idx == IdxW'(NumReq - 1)) ? '0 : gnt_idx + 1'b1;
  assign rdata_o  = device_rdata_i;

  // The grant is one-hot, so a plain priority mux selects the single active payload.
  always_comb begin
    device_req_o   = gnt_any;
    device_addr_o  = '0;
    device_we_o    = 1'b0;
    device_be_o    = '0;
    device_wdata_o = '0;
    for (int i = 0; i < NumReq; i++) begin
      if (gnt[i]) begin
        device_addr_o  = addr_i[i*RegAddr +: RegAddr];
        device_we_o    = we_i[i];
        device_be_o    = be_i[i*4 +: 4];
        device_wdata_o = wdata_i[i*DataWidth +: DataWidth];
      end
    end
  end

  // Pointer and the record of who is owed next cycle's response.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr_q       <= '0;
      owner_rsp_q <= '0;
      rsp_pend_q  <= 1'b0;
    end else begin
      if (gnt_any) begin
        ptr_q <= next_ptr;
      end
      owner_rsp_q <= gnt_idx;
      rsp_pend_q  <= gnt_any;
    end
  end

  // An owner write outranks the timeout, so a newline on the timeout cycle releases only once.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      lock_q  <= UNLOCKED;
      owner_q <= '0;
      cnt_q   <= '0;
    end else begin
      case (lock_q)
        UNLOCKED: begin
          if (gnt_tx && !gnt_nl) begin
            owner_q <= gnt_idx;
            cnt_q   <= '0;
            lock_q  <= LOCKED;
          end
        end
        LOCKED: begin
          if (gnt_tx && (gnt_idx == owner_q)) begin
            cnt_q <= '0;
            if (gnt_nl) begin
              lock_q <= UNLOCKED;
            end
          end else if (cnt_q == CntW'(LockTimeout - 1)) begin
            cnt_q  <= '0;
            lock_q <= UNLOCKED;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          lock_q <= UNLOCKED;
          cnt_q  <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_bus_arbiter.sv
// Directed bench for uart_bus_arbiter: inputs change on the falling edge and
// outputs are sampled 1 ns later, with a one-cycle-latency UART model.
module tb_uart_bus_arbiter;
  import uart_arb_pkg::*;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic [3:0]   req_i;
  logic [47:0]  addr_i;
  logic [3:0]   we_i;
  logic [15:0]  be_i;
  logic [127:0] wdata_i;
  logic [3:0]   gnt_o;
  logic [3:0]   rvalid_o;
  logic [31:0]  rdata_o;
  logic         device_req_o;
  logic [11:0]  device_addr_o;
  logic         device_we_o;
  logic [3:0]   device_be_o;
  logic [31:0]  device_wdata_o;
  logic         device_rvalid_i;
  logic [31:0]  device_rdata_i;

  logic         model_rvalid = 1'b0;
  logic [31:0]  model_rdata = '0;
  logic         force_rvalid = 1'b0;
  logic [7:0]   tx_log [64];
  int           tx_cnt = 0;

  int vectors = 0;
  int miscompares = 0;

  uart_bus_arbiter #(
    .NumReq(4), .DataWidth(32), .RegAddr(12), .LockTimeout(8)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .addr_i(addr_i), .we_i(we_i),
    .be_i(be_i), .wdata_i(wdata_i), .gnt_o(gnt_o), .rvalid_o(rvalid_o),
    .rdata_o(rdata_o), .device_req_o(device_req_o), .device_addr_o(device_addr_o),
    .device_we_o(device_we_o), .device_be_o(device_be_o),
    .device_wdata_o(device_wdata_o), .device_rvalid_i(device_rvalid_i),
    .device_rdata_i(device_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  // UART stand-in: answers every request one cycle later and records TX bytes.
  always @(posedge clk_i) begin
    model_rvalid <= device_req_o;
    model_rdata  <= {20'hABCDE, device_addr_o};
    if (device_req_o && device_we_o && device_be_o[0] && device_addr_o == 12'h001 && tx_cnt < 64) begin
      tx_log[tx_cnt] <= device_wdata_o[7:0];
      tx_cnt         <= tx_cnt + 1;
    end
  end

  assign device_rvalid_i = model_rvalid | force_rvalid;
  assign device_rdata_i  = model_rdata;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic next_cycle();
    @(negedge clk_i);
  endtask

  task automatic clr_all();
    req_i = '0; addr_i = '0; we_i = '0; be_i = '0; wdata_i = '0;
  endtask

  task automatic set_req(input int i, input logic [11:0] a, input logic w,
                         input logic [3:0] b, input logic [31:0] d);
    req_i[i] = 1'b1;
    addr_i[i*12 +: 12] = a;
    we_i[i] = w;
    be_i[i*4 +: 4] = b;
    wdata_i[i*32 +: 32] = d;
  endtask

  task automatic test_reset();
    next_cycle();
    set_req(0, 12'h002, 1'b0, 4'hF, 32'h0);
    set_req(2, 12'h002, 1'b0, 4'hF, 32'h0);
    #1;
    vectors++;
    if (gnt_o !== 4'b0000) begin miscompares++; $display("[TB] FAIL reset_gnt: got %b expected %b", gnt_o, 4'b0000); end
    vectors++;
    if (device_req_o !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_devreq: got %b expected 0", device_req_o); end
    next_cycle();
    rst_i = 1'b0;
    clr_all();
    #1;
    vectors++;
    if (dut.ptr_q !== 2'd0) begin miscompares++; $display("[TB] FAIL reset_ptr: got %0d expected 0", dut.ptr_q); end
    vectors++;
    if (dut.lock_q !== UNLOCKED) begin miscompares++; $display("[TB] FAIL reset_lock: got %0d expected 0", dut.lock_q); end
    vectors++;
    if (dut.cnt_q !== '0) begin miscompares++; $display("[TB] FAIL reset_cnt: got %0d expected 0", dut.cnt_q); end
    vectors++;
    if (rvalid_o !== 4'b0000) begin miscompares++; $display("[TB] FAIL reset_rvalid: got %b expected 0000", rvalid_o); end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_g;
    logic [3:0] exp_v;
    for (int c = 1; c <= 4; c++) begin
      next_cycle();
      if (c == 1) begin
        set_req(0, 12'h002, 1'b0, 4'hF, 32'h0);
        set_req(2, 12'h002, 1'b0, 4'hF, 32'h0);
      end
      #1;
      exp_g = (c % 2 == 1) ? 4'b0001 : 4'b0100;
      exp_v = (c == 1) ? 4'b0000 : ((c % 2 == 1) ? 4'b0100 : 4'b0001);
      vectors++;
      if (gnt_o !== exp_g) begin miscompares++; $display("[TB] FAIL rr_gnt c%0d: got %b expected %b", c, gnt_o, exp_g); end
      vectors++;
      if (rvalid_o !== exp_v) begin miscompares++; $display("[TB] FAIL rr_rvalid c%0d: got %b expected %b", c, rvalid_o, exp_v); end
      if (c > 1) begin
        vectors++;
        if (rdata_o !== 32'hABCDE002) begin miscompares++; $display("[TB] FAIL rr_rdata c%0d: got %h expected abcde002", c, rdata_o); end
      end
    end
    next_cycle();
    clr_all();
    #1;
    vectors++;
    if (gnt_o !== 4'b0000) begin miscompares++; $display("[TB] FAIL rr_idle_gnt: got %b expected 0000", gnt_o); end
    vectors++;
    if (rvalid_o !== 4'b0100) begin miscompares++; $display("[TB] FAIL rr_last_rvalid: got %b expected 0100", rvalid_o); end
    vectors++;
    if (dut.ptr_q !== 2'd3) begin miscompares++; $display("[TB] FAIL rr_ptr: got %0d expected 3", dut.ptr_q); end
  endtask

  task automatic test_line_lock();
    int base;
    base = tx_cnt;
    next_cycle();
    set_req(1, 12'h001, 1'b1, 4'h1, 32'h48);
    #1;
    vectors++;
    if (gnt_o !== 4'b0010) begin miscompares++; $display("[TB] FAIL lock_h_gnt: got %b expected 0010", gnt_o); end
    next_cycle();
    clr_all();
    set_req(3, 12'h001, 1'b1, 4'h1, 32'h58);
    #1;
    vectors++;
    if (gnt_o !== 4'b0000) begin miscompares++; $display("[TB] FAIL lock_block1: got %b expected 0000", gnt_o); end
    vectors++;
    if (dut.lock_q !== LOCKED) begin miscompares++; $display("[TB] FAIL lock_state: got %0d expected 1", dut.lock_q); end
    vectors++;
    if (dut.owner_q !== 2'd1) begin miscompares++; $display("[TB] FAIL lock_owner: got %0d expected 1", dut.owner_q); end
    next_cycle();
    #1;
    vectors++;
    if (gnt_o !== 4'b0000) begin miscompares++; $display("[TB] FAIL lock_block2: got %b expected 0000", gnt_o); end
    vectors++;
    if (dut.ptr_q !== 2'd2) begin miscompares++; $display("[TB] FAIL lock_ptr_hold: got %0d expected 2", dut.ptr_q); end
    next_cycle();
    set_req(1, 12'h001, 1'b1, 4'h1, 32'h0A);
    #1;
    vectors++;
    if (gnt_o !== 4'b0010) begin miscompares++; $display("[TB] FAIL lock_nl_gnt: got %b expected 0010", gnt_o); end
    next_cycle();
    req_i[1] = 1'b0;
    #1;
    vectors++;
    if (gnt_o !== 4'b1000) begin miscompares++; $display("[TB] FAIL lock_release_gnt: got %b expected 1000", gnt_o); end
    vectors++;
    if (dut.lock_q !== UNLOCKED) begin miscompares++; $display("[TB] FAIL lock_released: got %0d expected 0", dut.lock_q); end
    next_cycle();
    set_req(3, 12'h001, 1'b1, 4'h1, 32'h0A);
    #1;
    vectors++;
    if (gnt_o !== 4'b1000) begin miscompares++; $display("[TB] FAIL lock_req3_nl: got %b expected 1000", gnt_o); end
    next_cycle();
    clr_all();
    #1;
    vectors++;
    if (dut.lock_q !== UNLOCKED) begin miscompares++; $display("[TB] FAIL lock_final: got %0d expected 0", dut.lock_q); end
    vectors++;
    if (tx_cnt - base !== 4) begin miscompares++; $display("[TB] FAIL lock_tx_count: got %0d expected 4", tx_cnt - base); end
    vectors++;
    if (tx_log[base] !== 8'h48 || tx_log[base+1] !== 8'h0A || tx_log[base+2] !== 8'h58)
      begin miscompares++; $display("[TB] FAIL lock_order: got %h %h %h expected 48 0a 58", tx_log[base], tx_log[base+1], tx_log[base+2]); end
  endtask

  task automatic test_read_bypass();
    next_cycle();
    set_req(0, 12'h001, 1'b1, 4'h1, 32'h61);
    #1;
    vectors++;
    if (gnt_o !== 4'b0001) begin miscompares++; $display("[TB] FAIL byp_lock_gnt: got %b expected 0001", gnt_o); end
    next_cycle();
    clr_all();
    set_req(2, 12'h000, 1'b0, 4'hF, 32'h0);
    #1;
    vectors++;
    if (gnt_o !== 4'b0100) begin miscompares++; $display("[TB] FAIL byp_read_gnt: got %b expected 0100", gnt_o); end
    vectors++;
    if (dut.lock_q !== LOCKED) begin miscompares++; $display("[TB] FAIL byp_locked: got %0d expected 1", dut.lock_q); end
    next_cycle();
    clr_all();
    set_req(3, 12'h001, 1'b1, 4'b0010, 32'h77);
    #1;
    vectors++;
    if (gnt_o !== 4'b1000) begin miscompares++; $display("[TB] FAIL byp_be_gnt: got %b expected 1000", gnt_o); end
    vectors++;
    if (rvalid_o !== 4'b0100) begin miscompares++; $display("[TB] FAIL byp_rvalid: got %b expected 0100", rvalid_o); end
    vectors++;
    if (rdata_o !== 32'hABCDE000) begin miscompares++; $display("[TB] FAIL byp_rdata: got %h expected abcde000", rdata_o); end
    next_cycle();
    clr_all();
    set_req(0, 12'h001, 1'b1, 4'h1, 32'h0A);
    #1;
    vectors++;
    if (gnt_o !== 4'b0001) begin miscompares++; $display("[TB] FAIL byp_nl_gnt: got %b expected 0001", gnt_o); end
    next_cycle();
    clr_all();
    #1;
    vectors++;
    if (dut.lock_q !== UNLOCKED) begin miscompares++; $display("[TB] FAIL byp_unlock: got %0d expected 0", dut.lock_q); end
    vectors++;
    if (dut.ptr_q !== 2'd1) begin miscompares++; $display("[TB] FAIL byp_ptr: got %0d expected 1", dut.ptr_q); end
  endtask

  task automatic test_timeout();
    next_cycle();
    set_req(0, 12'h001, 1'b1, 4'h1, 32'h41);
    #1;
    vectors++;
    if (gnt_o !== 4'b0001) begin miscompares++; $display("[TB] FAIL to_lock_gnt: got %b expected 0001", gnt_o); end
    for (int k = 1; k <= 8; k++) begin
      next_cycle();
      if (k == 1) begin
        clr_all();
        set_req(1, 12'h001, 1'b1, 4'h1, 32'h42);
      end
      #1;
      vectors++;
      if (gnt_o !== 4'b0000) begin miscompares++; $display("[TB] FAIL to_blocked k%0d: got %b expected 0000", k, gnt_o); end
      if (k == 8) begin
        vectors++;
        if (dut.cnt_q !== 4'd7) begin miscompares++; $display("[TB] FAIL to_cnt: got %0d expected 7", dut.cnt_q); end
      end
    end
    next_cycle();
    #1;
    vectors++;
    if (gnt_o !== 4'b0010) begin miscompares++; $display("[TB] FAIL to_release_gnt: got %b expected 0010", gnt_o); end
    vectors++;
    if (dut.lock_q !== UNLOCKED) begin miscompares++; $display("[TB] FAIL to_unlocked: got %0d expected 0", dut.lock_q); end
    next_cycle();
    set_req(1, 12'h001, 1'b1, 4'h1, 32'h0A);
    #1;
    vectors++;
    if (gnt_o !== 4'b0010) begin miscompares++; $display("[TB] FAIL to_nl_gnt: got %b expected 0010", gnt_o); end
    next_cycle();
    clr_all();
    #1;
    vectors++;
    if (dut.lock_q !== UNLOCKED) begin miscompares++; $display("[TB] FAIL to_final: got %0d expected 0", dut.lock_q); end
  endtask

  task automatic test_newline_timeout();
    next_cycle();
    set_req(0, 12'h001, 1'b1, 4'h1, 32'h43);
    #1;
    vectors++;
    if (gnt_o !== 4'b0001) begin miscompares++; $display("[TB] FAIL nlto_lock_gnt: got %b expected 0001", gnt_o); end
    for (int k = 1; k <= 7; k++) begin
      next_cycle();
      clr_all();
      #1;
    end
    next_cycle();
    set_req(0, 12'h001, 1'b1, 4'h1, 32'h0A);
    #1;
    vectors++;
    if (dut.cnt_q !== 4'd7) begin miscompares++; $display("[TB] FAIL nlto_cnt_at_edge: got %0d expected 7", dut.cnt_q); end
    vectors++;
    if (gnt_o !== 4'b0001) begin miscompares++; $display("[TB] FAIL nlto_gnt: got %b expected 0001", gnt_o); end
    next_cycle();
    clr_all();
    #1;
    vectors++;
    if (dut.lock_q !== UNLOCKED) begin miscompares++; $display("[TB] FAIL nlto_unlocked: got %0d expected 0", dut.lock_q); end
    vectors++;
    if (dut.cnt_q !== 4'd0) begin miscompares++; $display("[TB] FAIL nlto_cnt: got %0d expected 0", dut.cnt_q); end
    next_cycle();
    #1;
    vectors++;
    if (dut.lock_q !== UNLOCKED) begin miscompares++; $display("[TB] FAIL nlto_relock: got %0d expected 0", dut.lock_q); end
  endtask

  task automatic test_back_to_back();
    logic [3:0]  exp_g;
    logic [3:0]  exp_v;
    logic [31:0] exp_d;
    int g;
    int p;
    for (int c = 0; c <= 4; c++) begin
      next_cycle();
      if (c == 0) begin
        for (int i = 0; i < 4; i++) set_req(i, 12'h010 + 12'(i), 1'b0, 4'hF, 32'h0);
      end
      if (c == 4) clr_all();
      #1;
      g = (1 + c) % 4;
      p = c % 4;
      exp_g = (c == 4) ? 4'b0000 : 4'(1 << g);
      vectors++;
      if (gnt_o !== exp_g) begin miscompares++; $display("[TB] FAIL b2b_gnt c%0d: got %b expected %b", c, gnt_o, exp_g); end
      if (c > 0) begin
        exp_v = 4'(1 << p);
        exp_d = 32'hABCDE010 + 32'(p);
        vectors++;
        if (rvalid_o !== exp_v) begin miscompares++; $display("[TB] FAIL b2b_rvalid c%0d: got %b expected %b", c, rvalid_o, exp_v); end
        vectors++;
        if (rdata_o !== exp_d) begin miscompares++; $display("[TB] FAIL b2b_rdata c%0d: got %h expected %h", c, rdata_o, exp_d); end
      end
    end
  endtask

  task automatic test_reset_mid();
    next_cycle();
    set_req(0, 12'h001, 1'b1, 4'h1, 32'h4C);
    #1;
    vectors++;
    if (gnt_o !== 4'b0001) begin miscompares++; $display("[TB] FAIL rm_lock_gnt: got %b expected 0001", gnt_o); end
    next_cycle();
    clr_all();
    set_req(1, 12'h002, 1'b0, 4'hF, 32'h0);
    #1;
    vectors++;
    if (gnt_o !== 4'b0010) begin miscompares++; $display("[TB] FAIL rm_gnt1: got %b expected 0010", gnt_o); end
    for (int k = 0; k < 2; k++) begin
      next_cycle();
      rst_i = 1'b1;
      #1;
      vectors++;
      if (gnt_o !== 4'b0000) begin miscompares++; $display("[TB] FAIL rm_gnt_in_reset k%0d: got %b expected 0000", k, gnt_o); end
      vectors++;
      if (device_req_o !== 1'b0) begin miscompares++; $display("[TB] FAIL rm_devreq_in_reset k%0d: got %b expected 0", k, device_req_o); end
    end
    next_cycle();
    rst_i = 1'b0;
    clr_all();
    force_rvalid = 1'b1;
    #1;
    vectors++;
    if (rvalid_o !== 4'b0000) begin miscompares++; $display("[TB] FAIL rm_rvalid_after: got %b expected 0000", rvalid_o); end
    vectors++;
    if (dut.ptr_q !== 2'd0) begin miscompares++; $display("[TB] FAIL rm_ptr: got %0d expected 0", dut.ptr_q); end
    vectors++;
    if (dut.lock_q !== UNLOCKED) begin miscompares++; $display("[TB] FAIL rm_lock: got %0d expected 0", dut.lock_q); end
    next_cycle();
    force_rvalid = 1'b0;
  endtask

  initial begin
    rst_i = 1'b1;
    clr_all();
    test_reset();
    test_round_robin();
    test_line_lock();
    test_read_bypass();
    test_timeout();
    test_newline_timeout();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
